// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared types and constants for the LCD bus sequencer.
// Holds the FSM state encoding, opcode constants, the power-on init ROM
// and the opcode -> execution-wait classifier.
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        ST_POWERON,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_DONE
    } lcd_state_e;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h25;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Controller init: 8-bit/2-line, display on, clear, entry mode.
    // Element 0 is issued first.
    localparam int INIT_LEN = 4;
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) need the long wait.
    function automatic logic wait_is_long(input logic [7:0] op);
        return (op == CMD_CLEAR) || (op[7:1] == CMD_HOME[7:1]);
    endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// lcd_seq_timer: loadable down-counter shared by all timed FSM states.
// A load of N-1 yields exactly N clk_en-qualified cycles until zero is seen.
// The counter pauses (and ignores load) while clk_en is low.
module lcd_seq_timer #(
    parameter int             W       = 20,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clk_en) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Counter register; reset value lets the power-on wait start counting at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: custom-instruction slave that owns the HD44780 LCD bus.
// One opcode per start/done transaction; drives RS/DATA with setup, enable
// pulse and hold timing, then waits out the controller execution time.
// Define LCD_SEQ_INIT_EN to build the power-on wait and init sequence.
module lcd_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = 3,
    parameter int unsigned EN_PULSE_CYC   = 25,
    parameter int unsigned HOLD_CYC       = 3,
    parameter int unsigned SHORT_WAIT_CYC = 2000,
    parameter int unsigned LONG_WAIT_CYC  = 82000,
    parameter int unsigned POWERON_CYC    = 750000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_backlight
);

    // Counter is sized for the longest waits; shorter phases fit trivially.
    localparam int unsigned MAX_CYC = (LONG_WAIT_CYC > POWERON_CYC) ? LONG_WAIT_CYC : POWERON_CYC;
    localparam int CNT_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(SHORT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_WAIT_CYC - 1);
`ifdef LCD_SEQ_INIT_EN
    localparam logic [CNT_W-1:0] TMR_RST  = CNT_W'(POWERON_CYC - 1);
    localparam lcd_state_e       ST_RST   = ST_POWERON;
`else
    localparam logic [CNT_W-1:0] TMR_RST  = '0;
    localparam lcd_state_e       ST_RST   = ST_IDLE;
`endif

    lcd_state_e  state_q, state_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] result_q, result_d;
    logic        long_q, long_d;
    logic        en_q, en_d;
    logic        done_q, done_d;
    logic        bl_q;
`ifdef LCD_SEQ_INIT_EN
    logic [1:0]  idx_q, idx_d;
    logic        init_q, init_d;
`endif

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    logic [7:0] op;
    logic       is_write;
    logic       unused_hi;

    assign op        = dataa[7:0];
    assign is_write  = (op == OP_WRITE);
    assign unused_hi = ^{dataa[31:8], datab[31:8]};

    lcd_seq_timer #(
        .W       (CNT_W),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state, bus word latch and timer loads; everything holds while clk_en is low.
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        data_d   = data_q;
        result_d = result_q;
        long_d   = long_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef LCD_SEQ_INIT_EN
        idx_d    = idx_q;
        init_d   = init_q;
`endif
        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_NOP) begin
                            state_d = ST_DONE;
                        end else begin
                            rs_d     = is_write;
                            data_d   = is_write ? datab[7:0] : op;
                            result_d = {23'b0, is_write, (is_write ? datab[7:0] : op)};
                            long_d   = wait_is_long(op);
                            state_d  = ST_SETUP;
                            tmr_load = 1'b1;
                            tmr_val  = LD_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) begin
                        state_d  = ST_PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = LD_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_zero) begin
                        state_d  = ST_HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = LD_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state_d  = ST_WAIT;
                        tmr_load = 1'b1;
                        tmr_val  = long_q ? LD_LONG : LD_SHORT;
                    end
                end
                ST_WAIT: begin
                    if (tmr_zero) begin
`ifdef LCD_SEQ_INIT_EN
                        // Init words finish silently; the last one drops into IDLE.
                        if (init_q) begin
                            if (idx_q == 2'(INIT_LEN - 1)) begin
                                init_d  = 1'b0;
                                state_d = ST_IDLE;
                            end else begin
                                idx_d   = idx_q + 2'd1;
                                state_d = ST_INIT;
                            end
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
`ifdef LCD_SEQ_INIT_EN
                ST_POWERON: begin
                    if (tmr_zero) begin
                        state_d = ST_INIT;
                    end
                end
                ST_INIT: begin
                    rs_d     = 1'b0;
                    data_d   = INIT_ROM[idx_q];
                    result_d = {23'b0, 1'b0, INIT_ROM[idx_q]};
                    long_d   = wait_is_long(INIT_ROM[idx_q]);
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // Registered strobes follow the next state so they are glitch-free.
        en_d   = (state_d == ST_PULSE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; async reset drops lcd_en and done immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RST;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            result_q <= 32'h0;
            long_q   <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            bl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            result_q <= result_d;
            long_q   <= long_d;
            en_q     <= en_d;
            done_q   <= done_d;
            bl_q     <= 1'b1;
        end
    end

`ifdef LCD_SEQ_INIT_EN
    // Init sequence progress; restarts from the first ROM word on every reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= 2'd0;
            init_q <= 1'b1;
        end else begin
            idx_q  <= idx_d;
            init_q <= init_d;
        end
    end
`endif

    assign done          = done_q;
    assign result        = result_q;
    assign lcd_data      = data_q;
    assign lcd_rs        = rs_q;
    assign lcd_rw        = 1'b0;
    assign lcd_en        = en_q;
    assign lcd_backlight = bl_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: randomized scoreboard bench for lcd_sequencer.
// Stimulus pushes expected done events and bus words; a negedge monitor
// pops and compares them whenever done or lcd_en activity is observed.
module tb_lcd_sequencer;

    localparam int S  = 2;
    localparam int P  = 4;
    localparam int H  = 2;
    localparam int SW = 10;
    localparam int LW = 50;
    localparam int PO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic        done;
    logic [31:0] result;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_backlight;

    lcd_sequencer #(
        .SETUP_CYC      (S),
        .EN_PULSE_CYC   (P),
        .HOLD_CYC       (H),
        .SHORT_WAIT_CYC (SW),
        .LONG_WAIT_CYC  (LW),
        .POWERON_CYC    (PO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .start         (start),
        .dataa         (dataa),
        .datab         (datab),
        .done          (done),
        .result        (result),
        .lcd_data      (lcd_data),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_en        (lcd_en),
        .lcd_backlight (lcd_backlight)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] res; } done_exp_t;
    typedef struct { int rise; logic rs; logic [7:0] data; int len; } bus_exp_t;

    done_exp_t   dq[$];
    bus_exp_t    bq[$];
    logic [31:0] last_res = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller execution time as the datasheet classifies opcodes.
    function automatic int exec_wait(input logic [7:0] o);
        return (o >= 8'h01 && o <= 8'h03) ? LW : SW;
    endfunction

    // Monitor: pop and compare on every done pulse and enable edge.
    bit       en_prev = 1'b0;
    bit       en_tracked = 1'b0;
    int       rise_cyc = 0;
    bus_exp_t cur;
    always @(negedge clk) begin
        if (!reset) begin
            en_prev = 1'b0;
        end else begin
            if (done) begin
                if (dq.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    done_exp_t de;
                    de = dq.pop_front();
                    chk("done_cycle", cyc, de.cyc);
                    chk("result", result, de.res);
                    chk("lcd_rw", lcd_rw, 0);
                    chk("backlight", lcd_backlight, 1);
                end
            end
            if (lcd_en && !en_prev) begin
                rise_cyc = cyc;
                if (bq.size() == 0) begin
                    en_tracked = 1'b0;
                    chk("spurious_en", 1, 0);
                end else begin
                    en_tracked = 1'b1;
                    cur = bq[0];
                    if (cur.rise >= 0) chk("en_rise_cycle", cyc, cur.rise);
                    chk("rs_at_rise", lcd_rs, cur.rs);
                    chk("data_at_rise", lcd_data, cur.data);
                end
            end
            if (!lcd_en && en_prev && en_tracked) begin
                void'(bq.pop_front());
                chk("en_width", cyc - rise_cyc, cur.len);
                chk("data_hold", lcd_data, cur.data);
                en_tracked = 1'b0;
            end
            en_prev = lcd_en;
        end
    end

    // Reset release; with init built, expect the four init words and wait for IDLE.
    task automatic release_reset();
        reset = 1'b1;
`ifdef LCD_SEQ_INIT_EN
        begin
            logic [7:0] rom [4];
            bus_exp_t   be;
            int         n;
            rom = '{8'h38, 8'h0C, 8'h01, 8'h06};
            foreach (rom[i]) begin
                be.rise = -1; be.rs = 1'b0; be.data = rom[i]; be.len = P;
                bq.push_back(be);
            end
            n = 0;
            while (bq.size() != 0 && n < 400) begin tick(); n++; end
            chk("init_words_seen", bq.size(), 0);
            bq.delete();
            repeat (H + SW + 4) tick();
        end
`endif
    endtask

    // Issue one transaction, push its expectations, optionally stall and poke start.
    task automatic issue(input logic [7:0] o, input logic [7:0] ch, input int k, input bit poke);
        int        t;
        done_exp_t de;
        bus_exp_t  be;
        logic      rs;
        logic [7:0] d;
        t = cyc;
        dataa = {24'($urandom), o};
        datab = {24'($urandom), ch};
        start = 1'b1;
        if (o == 8'h00) begin
            de.cyc = t + 1;
            de.res = last_res;
            dq.push_back(de);
            tick();
            start = 1'b0;
        end else begin
            rs = (o == 8'h25);
            d  = rs ? ch : o;
            last_res = {23'b0, rs, d};
            be.rise = t + 1 + S; be.rs = rs; be.data = d; be.len = P + k;
            bq.push_back(be);
            de.cyc = t + 1 + S + P + H + exec_wait(o) + k;
            de.res = last_res;
            dq.push_back(de);
            tick();
            start = 1'b0;
            dataa = $urandom;
            if (k > 0) begin
                while (cyc < t + S + 2) tick();
                clk_en = 1'b0;
                repeat (k) tick();
                clk_en = 1'b1;
            end
            if (poke) begin
                while (cyc < t + 1 + S + P + H + k + 2) tick();
                dataa = $urandom;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        while (cyc <= de.cyc) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] o;
        int         k, n;
        bit         poke;
        int         t;
        done_exp_t  de;
        bus_exp_t   be;

        #1;
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_lcd_data", lcd_data, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_rw", lcd_rw, 0);
        chk("rst_lcd_en", lcd_en, 0);
        chk("rst_backlight", lcd_backlight, 0);
        repeat (3) tick();
        release_reset();
        tick();
        chk("backlight_on", lcd_backlight, 1);

        issue(8'h25, 8'h41, 0, 1'b0);
        issue(8'h01, 8'h00, 0, 1'b0);
        issue(8'h0E, 8'h00, 0, 1'b0);
        issue(8'h00, 8'h00, 0, 1'b0);
        issue(8'h25, 8'h5A, 5, 1'b1);
        issue(8'h03, 8'h00, 2, 1'b1);

        // Abort a write mid-pulse with an asynchronous reset.
        t = cyc;
        dataa = 32'h25; datab = 32'h77; start = 1'b1;
        be.rise = t + 1 + S; be.rs = 1'b1; be.data = 8'h77; be.len = P;
        bq.push_back(be);
        de.cyc = t + 1 + S + P + H + SW; de.res = 32'h177;
        dq.push_back(de);
        tick();
        start = 1'b0;
        while (cyc < t + S + 2) tick();
        #2 reset = 1'b0;
        #1;
        chk("abort_lcd_en", lcd_en, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        dq.delete();
        bq.delete();
        last_res = '0;
        repeat (2) tick();
        release_reset();
        repeat (SW + LW) tick();

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 5))
                0: o = 8'h00;
                1: o = 8'h25;
                2: o = 8'h01;
                3: o = 8'h02;
                4: o = 8'h03;
                default: o = 8'($urandom);
            endcase
            k    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            poke = 1'($urandom_range(0, 1));
            if (o == 8'h00) begin k = 0; poke = 1'b0; end
            repeat ($urandom_range(0, 3)) tick();
            issue(o, 8'($urandom), k, poke);
        end

        n = 0;
        while ((dq.size() != 0 || bq.size() != 0) && n < 200) begin tick(); n++; end
        chk("drain_done_queue", dq.size(), 0);
        chk("drain_bus_queue", bq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
